// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings and defaults for the front-panel time-setting sequencer.
package clock_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SET_H = 3'd1,
    ST_SET_M = 3'd2,
    ST_SET_S = 3'd3,
    ST_LOAD  = 3'd4
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int DEF_HOUR_MAX      = 23;
  localparam int DEF_MINSEC_MAX    = 59;
  localparam int DEF_TIMEOUT_TICKS = 10;

  // Out-of-range live values are captured as zero so editing starts from a legal time.
  function automatic logic [5:0] clamp_capture(input logic [5:0] value,
                                               input logic [5:0] max_val);
    return (value > max_val) ? 6'd0 : value;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_wrap_updown.sv
// 6-bit up/down step with wrap-around between 0 and max_val.
module wrap_updown (
  input  logic [5:0] value,
  input  logic       inc,
  input  logic       dec,
  input  logic [5:0] max_val,
  output logic [5:0] wrapped
);

  always_comb begin
    wrapped = value;
    if (inc && !dec) begin
      wrapped = (value == max_val) ? 6'd0 : value + 6'd1;
    end else if (dec && !inc) begin
      wrapped = (value == 6'd0) ? max_val : value - 6'd1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: button edges drive RUN -> SET_H -> SET_M -> SET_S -> LOAD,
// editing shadow time registers and issuing a single load strobe to the counter.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int HOUR_MAX      = DEF_HOUR_MAX,
  parameter int MINSEC_MAX    = DEF_MINSEC_MAX,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       run_en,
  output logic       load_time,
  output logic [5:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [1:0] field_sel,
  output logic [5:0] blink_mask,
  output logic       set_active
);

  localparam int             TO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [5:0]     HMAX6   = 6'(HOUR_MAX);
  localparam logic [5:0]     MSMAX6  = 6'(MINSEC_MAX);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  state_e          state_q, state_d;
  logic            mode_prev_q, inc_prev_q, dec_prev_q;
  logic            mode_pls_q, inc_pls_q, dec_pls_q;
  logic            mode_pls_d, inc_pls_d, dec_pls_d;
  logic [5:0]      hour_q, min_q, sec_q;
  logic [5:0]      hour_d, min_d, sec_d;
  logic [5:0]      hour_nxt, min_nxt, sec_nxt;
  logic            phase_q, phase_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic mode_ev, inc_ev, dec_ev, any_pls, is_set;

  // Pulses are registered so the edit lands two clocks after the button rises.
  assign mode_pls_d = btn_mode & ~mode_prev_q;
  assign inc_pls_d  = btn_inc  & ~inc_prev_q;
  assign dec_pls_d  = btn_dec  & ~dec_prev_q;

  assign mode_ev = mode_pls_q;
  assign inc_ev  = inc_pls_q & ~dec_pls_q & ~mode_pls_q;
  assign dec_ev  = dec_pls_q & ~inc_pls_q & ~mode_pls_q;
  assign any_pls = mode_pls_q | inc_pls_q | dec_pls_q;
  assign is_set  = (state_q == ST_SET_H) || (state_q == ST_SET_M) || (state_q == ST_SET_S);

  wrap_updown u_wrap_hour (
    .value   (hour_q),
    .inc     (inc_ev && (state_q == ST_SET_H)),
    .dec     (dec_ev && (state_q == ST_SET_H)),
    .max_val (HMAX6),
    .wrapped (hour_nxt)
  );

  wrap_updown u_wrap_min (
    .value   (min_q),
    .inc     (inc_ev && (state_q == ST_SET_M)),
    .dec     (dec_ev && (state_q == ST_SET_M)),
    .max_val (MSMAX6),
    .wrapped (min_nxt)
  );

  wrap_updown u_wrap_sec (
    .value   (sec_q),
    .inc     (inc_ev && (state_q == ST_SET_S)),
    .dec     (dec_ev && (state_q == ST_SET_S)),
    .max_val (MSMAX6),
    .wrapped (sec_nxt)
  );

  always_comb begin
    state_d  = state_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    phase_d  = tick ? ~phase_q : phase_q;
    to_cnt_d = to_cnt_q;

    if (is_set) begin
      if (any_pls) begin
        to_cnt_d = '0;
      end else if (tick) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    case (state_q)
      ST_RUN: begin
        if (mode_ev) begin
          hour_d   = clamp_capture(cur_hour, HMAX6);
          min_d    = clamp_capture(cur_min, MSMAX6);
          sec_d    = clamp_capture(cur_sec, MSMAX6);
          phase_d  = 1'b0;
          to_cnt_d = '0;
          state_d  = ST_SET_H;
        end
      end
      ST_SET_H: begin
        hour_d = hour_nxt;
        if (mode_ev) state_d = ST_SET_M;
      end
      ST_SET_M: begin
        min_d = min_nxt;
        if (mode_ev) state_d = ST_SET_S;
      end
      ST_SET_S: begin
        sec_d = sec_nxt;
        if (mode_ev) state_d = ST_LOAD;
      end
      ST_LOAD:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // Abandon the edit: shadow is kept but never loaded.
    if (is_set && !any_pls && tick && (to_cnt_q == TO_LAST)) begin
      state_d  = ST_RUN;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      dec_prev_q  <= 1'b0;
      mode_pls_q  <= 1'b0;
      inc_pls_q   <= 1'b0;
      dec_pls_q   <= 1'b0;
      hour_q      <= 6'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      phase_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      dec_prev_q  <= btn_dec;
      mode_pls_q  <= mode_pls_d;
      inc_pls_q   <= inc_pls_d;
      dec_pls_q   <= dec_pls_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      phase_q     <= phase_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    run_en     = (state_q == ST_RUN);
    load_time  = (state_q == ST_LOAD);
    set_active = is_set;
    load_hour  = hour_q;
    load_min   = min_q;
    load_sec   = sec_q;
    field_sel  = FIELD_NONE;
    blink_mask = 6'b000000;
    case (state_q)
      ST_SET_H: field_sel = FIELD_HOUR;
      ST_SET_M: field_sel = FIELD_MIN;
      ST_SET_S: field_sel = FIELD_SEC;
      default:  field_sel = FIELD_NONE;
    endcase
    if (is_set && phase_q) begin
      case (field_sel)
        FIELD_HOUR: blink_mask = 6'b110000;
        FIELD_MIN:  blink_mask = 6'b001100;
        FIELD_SEC:  blink_mask = 6'b000011;
        default:    blink_mask = 6'b000000;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed button/tick sequences with hand-computed results.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [5:0] cur_hour = 6'd12, cur_min = 6'd34, cur_sec = 6'd56;
  logic       run_en, load_time, set_active;
  logic [5:0] load_hour, load_min, load_sec, blink_mask;
  logic [1:0] field_sel;

  always #5 clk = ~clk;

  clock_set_ctrl dut (
    .clk        (clk),
    .RESET      (RESET),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .run_en     (run_en),
    .load_time  (load_time),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .field_sel  (field_sel),
    .blink_mask (blink_mask),
    .set_active (set_active)
  );

  typedef struct packed {
    logic       run_en;
    logic       load_time;
    logic [1:0] field;
    logic       set_act;
    logic [5:0] blink;
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } snap_t;

  snap_t       exp_snap_q[$];
  string       exp_name_q[$];
  logic [17:0] exp_load_q[$];
  snap_t       act, exp_s;
  logic [17:0] exp_ld;
  string       nm;
  int          total = 0;
  int          bad = 0;
  logic        chk_req = 1'b0;
  logic        done = 1'b0;

  assign act = {run_en, load_time, field_sel, set_active, blink_mask, load_hour, load_min, load_sec};

  // Monitor: owns all counters, compares load strobes and requested snapshots.
  always @(negedge clk) begin
    if (load_time) begin
      total++;
      if (exp_load_q.size() == 0) begin
        bad++;
        $display("FAIL load_unexpected got=%0d:%0d:%0d want=no pulse", load_hour, load_min, load_sec);
      end else begin
        exp_ld = exp_load_q.pop_front();
        if ({load_hour, load_min, load_sec} !== exp_ld) begin
          bad++;
          $display("FAIL load_value got=%0d:%0d:%0d want=%0d:%0d:%0d", load_hour, load_min, load_sec,
                   exp_ld[17:12], exp_ld[11:6], exp_ld[5:0]);
        end
      end
    end
    if (chk_req) begin
      total++;
      if (exp_snap_q.size() == 0) begin
        bad++;
        $display("FAIL snapshot_missing got=%h want=queued entry", act);
      end else begin
        exp_s = exp_snap_q.pop_front();
        nm    = exp_name_q.pop_front();
        if (act !== exp_s) begin
          bad++;
          $display("FAIL %s got run=%b ld=%b fs=%0d set=%b blink=%b t=%0d:%0d:%0d want run=%b ld=%b fs=%0d set=%b blink=%b t=%0d:%0d:%0d",
                   nm, act.run_en, act.load_time, act.field, act.set_act, act.blink, act.h, act.m, act.s,
                   exp_s.run_en, exp_s.load_time, exp_s.field, exp_s.set_act, exp_s.blink, exp_s.h, exp_s.m, exp_s.s);
        end
      end
    end
    if (done) begin
      total++;
      if (exp_load_q.size() != 0) begin
        bad++;
        $display("FAIL load_missing got=%0d pending want=0 pending", exp_load_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    step();
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic check(input string name, input logic run, input logic lt, input logic [1:0] f,
                       input logic sa, input logic [5:0] bl, input logic [5:0] h,
                       input logic [5:0] m, input logic [5:0] s);
    exp_snap_q.push_back({run, lt, f, sa, bl, h, m, s});
    exp_name_q.push_back(name);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1, 0, 0, 0, 6'b0, 0, 0, 0);
    step();
    RESET = 1'b0;
    step();

    // Plain pass through all fields loads the captured time unchanged.
    press(1, 0, 0); check("t1_seth", 0, 0, 1, 1, 6'b0, 12, 34, 56);
    press(1, 0, 0); check("t1_setm", 0, 0, 2, 1, 6'b0, 12, 34, 56);
    press(1, 0, 0); check("t1_sets", 0, 0, 3, 1, 6'b0, 12, 34, 56);
    exp_load_q.push_back({6'd12, 6'd34, 6'd56});
    press(1, 0, 0);
    step();
    check("t1_run", 1, 0, 0, 0, 6'b0, 12, 34, 56);
    press(0, 1, 0);
    press(0, 0, 1);
    check("run_ignores_incdec", 1, 0, 0, 0, 6'b0, 12, 34, 56);

    // Wrap boundaries, out-of-range capture, simultaneous buttons.
    cur_hour = 6'd23; cur_min = 6'd61; cur_sec = 6'd0;
    press(1, 0, 0); check("capture_clamp", 0, 0, 1, 1, 6'b0, 23, 0, 0);
    press(0, 1, 0); check("hour_wrap_up", 0, 0, 1, 1, 6'b0, 0, 0, 0);
    press(0, 0, 1); check("hour_wrap_down", 0, 0, 1, 1, 6'b0, 23, 0, 0);
    press(1, 0, 0);
    press(0, 1, 1); check("incdec_together", 0, 0, 2, 1, 6'b0, 23, 0, 0);
    press(1, 1, 0); check("mode_beats_inc", 0, 0, 3, 1, 6'b0, 23, 0, 0);
    press(0, 0, 1); check("sec_wrap_down", 0, 0, 3, 1, 6'b0, 23, 0, 59);
    exp_load_q.push_back({6'd23, 6'd0, 6'd59});
    press(1, 0, 0);
    step();
    check("t2_run", 1, 0, 0, 0, 6'b0, 23, 0, 59);

    // Blink alternation and plain timeout out of SET_H.
    cur_hour = 6'd1; cur_min = 6'd2; cur_sec = 6'd3;
    press(1, 0, 0); check("t3_seth", 0, 0, 1, 1, 6'b0, 1, 2, 3);
    do_tick(1); check("blink_on_1", 0, 0, 1, 1, 6'b110000, 1, 2, 3);
    do_tick(1); check("blink_off_2", 0, 0, 1, 1, 6'b000000, 1, 2, 3);
    do_tick(1); check("blink_on_3", 0, 0, 1, 1, 6'b110000, 1, 2, 3);
    do_tick(6); check("seth_tick9", 0, 0, 1, 1, 6'b110000, 1, 2, 3);
    do_tick(1); check("timeout_seth", 1, 0, 0, 0, 6'b0, 1, 2, 3);
    do_tick(1); check("run_no_blink", 1, 0, 0, 0, 6'b0, 1, 2, 3);

    // Button on tick 9 restarts the timeout; exit after 19 ticks total.
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0); check("t4_sets", 0, 0, 3, 1, 6'b0, 1, 2, 3);
    do_tick(9); check("sets_tick9", 0, 0, 3, 1, 6'b000011, 1, 2, 3);
    press(0, 1, 0); check("sets_inc_restart", 0, 0, 3, 1, 6'b000011, 1, 2, 4);
    do_tick(9); check("sets_tick18", 0, 0, 3, 1, 6'b000000, 1, 2, 4);
    do_tick(1); check("timeout_sets", 1, 0, 0, 0, 6'b0, 1, 2, 4);

    // Asynchronous reset in the middle of an edit.
    cur_hour = 6'd5; cur_min = 6'd6; cur_sec = 6'd7;
    press(1, 0, 0);
    press(1, 0, 0); check("t5_setm", 0, 0, 2, 1, 6'b0, 5, 6, 7);
    step();
    RESET = 1'b1;
    check("reset_mid_setm", 1, 0, 0, 0, 6'b0, 0, 0, 0);
    RESET = 1'b0;
    step();
    step();
    check("after_reset", 1, 0, 0, 0, 6'b0, 0, 0, 0);

    step();
    done = 1'b1;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-setting sequencer for the HH:MM:SS clock counter.
- Turns debounced front-panel buttons into a RUN / set-hour / set-minute / set-second mode sequence.
- Keeps shadow time registers while the clock is being set, and issues a single load pulse with the edited time.
- Drives the counter's run enable and the display's per-digit blink mask; sits between the debouncers and the clock counter / 7-segment scan path.

Parameters:
- HOUR_MAX, 23, largest hour value; wraps to 0.
- MINSEC_MAX, 59, largest minute/second value; wraps to 0.
- TIMEOUT_TICKS, 10, number of tick pulses with no button press after which setting is abandoned.

Ports:
- clk  in  1  system clock.
- RESET  in  1  asynchronous reset, active-high.
- tick  in  1  one-clk-wide pulse at the seconds rate (clock enable).
- btn_mode  in  1  debounced level, mode/advance button.
- btn_inc  in  1  debounced level, increment button.
- btn_dec  in  1  debounced level, decrement button.
- cur_hour  in  6  live hour from the clock counter.
- cur_min  in  6  live minute from the clock counter.
- cur_sec  in  6  live second from the clock counter.
- run_en  out  1  counter count enable.
- load_time  out  1  one-cycle load strobe to the counter.
- load_hour  out  6  shadow hour value.
- load_min  out  6  shadow minute value.
- load_sec  out  6  shadow second value.
- field_sel  out  2  0 none, 1 hour, 2 min, 3 sec.
- blink_mask  out  6  digit blank enables {hourten, hourone, minten, minone, secten, secone}.
- set_active  out  1  high in any SET state.

Behaviour:
- Reset values (all asynchronous on RESET=1):
  - state=RUN, run_en=1, load_time=0, load_*=0, field_sel=0, blink_mask=0, set_active=0.
  - Edge-detect registers=0, blink phase=0, timeout counter=0.
- Button edge detection:
  - Each button has a prev register; pulse = level & ~prev.
  - A button held across reset release produces no pulse if prev is loaded after reset deassertion. With prev=0 at reset, it produces one pulse on the first clk.
  - The state and shadow regs react on the clk edge after the pulse cycle, so latency from the button's rising level to effect is 2 clk.
- Priority of events in one cycle: mode pulse beats inc/dec. inc and dec together are ignored. A tick in the same cycle is handled independently (timeout/blink).
- States:
  - RUN: run_en=1, field_sel=0. On mode: shadow ← cur_* (any value above its max is captured as 0), then go to SET_H. inc/dec are ignored.
  - SET_H: field_sel=1. inc: hour = (hour==HOUR_MAX)?0:hour+1. dec: hour = (hour==0)?HOUR_MAX:hour-1. On mode: go to SET_M.
  - SET_M: field_sel=2. Same wrap rules using MINSEC_MAX. On mode: go to SET_S.
  - SET_S: field_sel=3. Same wrap rules. On mode: go to LOAD.
  - LOAD: lasts exactly one cycle. load_time=1, load_* hold the shadow values, run_en=0. Next state is RUN unconditionally; buttons are ignored.
- run_en is 0 in all SET states and in LOAD. set_active is 1 in SET_H/M/S only.
- Timeout:
  - The counter clears on entry to SET_H and on any mode/inc/dec pulse.
  - It increments on tick while in a SET state.
  - On reaching TIMEOUT_TICKS it goes to RUN with no load pulse. The shadow keeps its values, and the clock resumes from its unmodified time.
- Blink:
  - The phase register toggles on every tick and is reset to 0 on SET_H entry.
  - blink_mask = selected field's two bits set while phase=1 in a SET state, else 0.
- Async reset mid-setting returns to RUN immediately with no load.

Decomposition:
- Shared package: state encodings (RUN, SET_H, SET_M, SET_S, LOAD), field_sel codes, and default max constants.
- One natural sub-module, wrap_updown, used three times: a 6-bit value with inc/dec/max inputs and wrap-around output.

Test Plan:
- Reset mid-SET_M: assert RESET → state RUN, run_en=1, field_sel=0, load_time never pulses.
- cur=12:34:56, press mode ×4 with no inc/dec → one load_time pulse with load=12:34:56, then run_en=1.
- In SET_H with hour=23: press inc → 0. Press dec → 23. In SET_S with sec=0: press dec → 59.
- In SET_M: hold inc and dec together for one edge → minute unchanged. Press mode and inc in the same cycle → SET_S, minute unchanged.
- In SET_S: give 10 tick pulses with no buttons → RUN, load_time stays 0, run_en=1. A button on tick 9 restarts the count (exit after 19 ticks).
- In SET_H with ticks: blink_mask alternates 6'b110000 / 0 per tick. In RUN, blink_mask stays 0.
